// File: rtl/ram_burst_pkg.sv
// Shared types and sizing constants for the RAM burst master and its read FIFO.
package ram_burst_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int RD_FIFO_DEPTH = 4;
  localparam int MAX_INFLIGHT  = 2;
  localparam int PTR_W         = $clog2(RD_FIFO_DEPTH);
  localparam int CNT_W         = $clog2(RD_FIFO_DEPTH + 1);
endpackage

// File: rtl/ram_rd_fifo.sv
// Small read-return FIFO holding RAM data plus its end-of-burst tag.
module ram_rd_fifo
  import ram_burst_pkg::*;
#(
  parameter int WIDTH = 33
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem_r [RD_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             pop_s;
  logic             push_s;

  assign empty  = (count_r == {CNT_W{1'b0}});
  assign full   = (count_r == CNT_W'(RD_FIFO_DEPTH));
  assign pop_s  = pop & ~empty;
  assign push_s = push & (~full | pop_s);
  assign head   = mem_r[rd_ptr_r];
  assign count  = count_r;

  // Storage, pointers and occupancy.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RD_FIFO_DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/ram_burst_master.sv
// Burst initiator for one synchronous-read RAM: wrapping address walk, streamed
// write data, and a credit-limited read pipeline feeding a small return FIFO.
module ram_burst_master
  import ram_burst_pkg::*;
#(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [AWIDTH-1:0] cmd_addr,
  input  logic [AWIDTH:0]   cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DWIDTH-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DWIDTH-1:0] rd_data,
  output logic              rd_last,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0] ram_din,
  output logic              ram_we,
  input  logic [DWIDTH-1:0] ram_dout,
  output logic              busy
);

  localparam logic [AWIDTH-1:0] ADDR_ONE = {{(AWIDTH-1){1'b0}}, 1'b1};
  localparam logic [AWIDTH:0]   REM_ONE  = {{AWIDTH{1'b0}}, 1'b1};

  state_t            state_r;
  state_t            state_nxt_s;
  logic [AWIDTH-1:0] addr_r;
  logic [AWIDTH:0]   rem_r;
  logic              pend_r;
  logic              pend_last_r;
  logic [1:0]        inflight_r;
  logic              issue_s;
  logic              credit_ok_s;
  logic              cmd_accept_s;
  logic              wr_beat_s;
  logic              pop_s;
  logic              drain_done_s;
  logic [DWIDTH:0]   fifo_head_s;
  logic [CNT_W-1:0]  fifo_count_s;
  logic              fifo_empty_s;
  logic              fifo_full_s;

  assign cmd_accept_s = cmd_valid & (state_r == IDLE);
  assign wr_beat_s    = (state_r == WRITE) & wr_valid;
  assign pop_s        = rd_valid & rd_ready;
  // A read may issue only if its data, plus everything already owed, fits the FIFO.
  assign credit_ok_s  = (({1'b0, fifo_count_s} + {2'b00, inflight_r}) < 4'(RD_FIFO_DEPTH))
                        & (inflight_r < 2'(MAX_INFLIGHT)) & ~fifo_full_s;
  // Leave DRAIN in the same cycle the final word pops, so cmd_ready rises right after.
  assign drain_done_s = ~pend_r & ((fifo_count_s == {CNT_W{1'b0}}) |
                        ((fifo_count_s == {{(CNT_W-1){1'b0}}, 1'b1}) & pop_s));

  assign ram_addr = addr_r;
  assign rd_valid = ~fifo_empty_s;
  assign rd_data  = fifo_empty_s ? {DWIDTH{1'b0}} : fifo_head_s[DWIDTH-1:0];
  assign rd_last  = ~fifo_empty_s & fifo_head_s[DWIDTH];

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (cmd_accept_s && (cmd_len != {(AWIDTH+1){1'b0}})) begin
          state_nxt_s = cmd_we ? WRITE : READ;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WRITE: begin
        if (wr_beat_s && (rem_r == REM_ONE)) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WRITE;
        end
      end
      READ: begin
        if (issue_s && (rem_r == REM_ONE)) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = READ;
        end
      end
      DRAIN: begin
        if (drain_done_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Per-state outputs and RAM controls.
  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b1;
    wr_ready  = 1'b0;
    ram_we    = 1'b0;
    ram_din   = {DWIDTH{1'b0}};
    issue_s   = 1'b0;
    case (state_r)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      WRITE: begin
        wr_ready = 1'b1;
        ram_we   = wr_valid;
        ram_din  = wr_data;
      end
      READ: begin
        issue_s = credit_ok_s;
      end
      DRAIN: begin
        busy = 1'b1;
      end
      default: begin
        cmd_ready = 1'b0;
        busy      = 1'b1;
      end
    endcase
  end

  // Burst address and remaining-word counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_r <= {AWIDTH{1'b0}};
      rem_r  <= {(AWIDTH+1){1'b0}};
    end else if (cmd_accept_s) begin
      addr_r <= cmd_addr;
      rem_r  <= cmd_len;
    end else if (wr_beat_s || issue_s) begin
      addr_r <= addr_r + ADDR_ONE;
      rem_r  <= rem_r - REM_ONE;
    end else begin
      addr_r <= addr_r;
      rem_r  <= rem_r;
    end
  end

  // Read pipeline: an issue this cycle means ram_dout is valid next cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pend_r      <= 1'b0;
      pend_last_r <= 1'b0;
      inflight_r  <= 2'd0;
    end else begin
      pend_r      <= issue_s;
      pend_last_r <= issue_s & (rem_r == REM_ONE);
      case ({issue_s, pend_r})
        2'b10:   inflight_r <= inflight_r + 2'd1;
        2'b01:   inflight_r <= inflight_r - 2'd1;
        default: inflight_r <= inflight_r;
      endcase
    end
  end

  ram_rd_fifo #(
    .WIDTH(DWIDTH + 1)
  ) u_rd_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .push     (pend_r),
    .push_data({pend_last_r, ram_dout}),
    .pop      (pop_s),
    .head     (fifo_head_s),
    .count    (fifo_count_s),
    .empty    (fifo_empty_s),
    .full     (fifo_full_s)
  );

endmodule

// File: doc/ram_burst_master.md
# ram_burst_master

Burst initiator for the single-port synchronous-read data RAMs (`addr`/`din`/`we` in, `dout` out, read data valid one cycle after address is clocked in). Accepts one read or write burst command at a time over a valid/ready interface and walks consecutive, wrapping RAM addresses. Write data streams in and read data streams out over valid/ready channels. Sits between a datapath or DMA client and one RAM instance, so no client ever drives the RAM port directly.

## Interface
- AWIDTH, 3: RAM address width; DEPTH = 1 << AWIDTH
- DWIDTH, 32: data width
- clock  in  1  rising-edge clock, shared with the RAM
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_we  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  AWIDTH  start address
- cmd_len  in  AWIDTH+1  word count, 0..DEPTH; 0 = no-op
- wr_valid / wr_ready / wr_data  in / out / in, DWIDTH  write-data stream
- rd_valid / rd_ready / rd_data  out / in / out, DWIDTH  read-data stream
- rd_last  out  1  qualifies the final rd_data word of a burst
- ram_addr  out  AWIDTH  to RAM addr
- ram_din  out  DWIDTH  to RAM din
- ram_we  out  1  to RAM we
- ram_dout  in  DWIDTH  from RAM dout
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, WRITE, READ, DRAIN.
- IDLE: cmd_ready=1. On accept, latch addr_q=cmd_addr and rem_q=cmd_len.
  - len 0: stay IDLE, no RAM access.
  - Otherwise go to WRITE if cmd_we=1, else READ.
- WRITE:
  - wr_ready=1; ram_we = wr_valid; ram_din = wr_data; ram_addr = addr_q.
  - Each accepted beat: addr_q+1 modulo DEPTH (wraps DEPTH-1 to 0), rem_q-1.
  - The last beat (rem_q==1) returns to IDLE.
- READ:
  - ram_addr = addr_q; ram_we=0.
  - Issue a read when credits allow: fifo_count + inflight < 4 (inflight ≤ 2).
  - Each issue: addr_q+1 wrapping, rem_q-1, and a last tag set when rem_q==1.
  - After the final issue, go to DRAIN.
- Read return path:
  - ram_dout is sampled the cycle after the address cycle.
  - It is pushed with its last tag into a 4-entry FIFO, which drives rd_valid/rd_data/rd_last.
  - The credit rule guarantees the FIFO never overflows.
- DRAIN: go to IDLE when the FIFO is empty and inflight==0.
- wr_ready=0 outside WRITE; wr_data is ignored there.
- ram_we is 0 outside WRITE.
- Read data is never dropped or reordered.
- rd_valid/rd_data/rd_last are held stable while rd_valid & !rd_ready.

## Timing
- Reset (asynchronous, any state, including mid-burst):
  - State IDLE; FIFO and inflight cleared; addr_q=0, rem_q=0.
  - Outputs: cmd_ready=1, busy=0, wr_ready=0, rd_valid=0, rd_last=0, rd_data=0, ram_we=0, ram_addr=0, ram_din=0.
  - An interrupted burst is abandoned, with no further RAM writes.
- Command accept cycle 0: first RAM access in cycle 1.
- Write: one word per cycle while wr_valid=1. The RAM commits at the end of each ram_we cycle.
- Read:
  - Address in cycle 1, ram_dout valid in cycle 2, FIFO push at the end of cycle 2.
  - First rd_valid in cycle 3.
  - With rd_ready held high, throughput is one word per cycle.
- Next command: cmd_ready rises the cycle after the write last beat, or the cycle after the final read word pops in DRAIN.
- A write burst that immediately follows a read burst never overlaps it: DRAIN completes first.
- Wrap: start address DEPTH-1 with len 2 accesses DEPTH-1 then 0.
- Len DEPTH accesses every location exactly once.

## Structure
- Package ram_burst_pkg holds:
  - state_t enum (IDLE, WRITE, READ, DRAIN)
  - RD_FIFO_DEPTH = 4
  - MAX_INFLIGHT = 2
- Sub-module ram_rd_fifo:
  - 4-entry synchronous FIFO, width DWIDTH+1 (data plus last tag).
  - Outputs count, empty and full; asynchronous active-low reset.

## Test plan
- Write burst: cmd_we=1, addr 2, len 3, data 0xA, 0xB, 0xC with wr_valid continuous.
  - ram_we high for 3 cycles at addresses 2, 3, 4.
  - cmd_ready returns one cycle after the last beat.
- Read-back: read addr 2, len 3, rd_ready=1.
  - rd_data 0xA, 0xB, 0xC on consecutive cycles starting at cycle 3.
  - rd_last only on 0xC.
- Wrap: write addr 7 len 2 (0x11, 0x22), then read addr 7 len 2.
  - Accesses at addresses 7 then 0; read returns 0x11, 0x22.
- Backpressure: read len 8 (DEPTH) with rd_ready toggling every other cycle.
  - All 8 words returned in order with no loss; FIFO count never exceeds 4; rd_data stable while stalled.
- Edge commands:
  - len 0: cmd_ready stays 1, with no ram_we or rd_valid.
  - Write with wr_valid gaps: ram_we only on valid cycles; address advances only then.
- Reset mid-read: assert reset_n=0 after 2 of 6 words are returned.
  - All outputs take reset values immediately.
  - After release: cmd_ready=1, rd_valid=0, no further ram accesses.
